// File: rtl/rf_arb_pkg.sv
// Shared types and width helpers for the register-file write-port arbiter.
// Also used by other shared-port arbiters built on rr_arbiter.
package rf_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wait_w(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/rf_wr_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward with wrap. Returns one-hot grant and its index.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx,
    output logic           gnt_any
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin write-port arbiter with burst lock, idle timeout and
// per-requester starvation flags, feeding a registered RF write stage.
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int MAX_WAIT     = 15,
    parameter int LOCK_TIMEOUT = 16,
    parameter int ZERO_RO      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic                          rf_wr_en,
    output logic [ADDR_WIDTH-1:0]         rf_wr_addr,
    output logic [DATA_WIDTH-1:0]         rf_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          locked,
    output logic                          lock_abort,
    output logic [NUM_REQ-1:0]            starve
);

    localparam int ID_W   = id_w(NUM_REQ);
    localparam int WAIT_W = wait_w(MAX_WAIT);
    localparam int IDLE_W = $clog2(LOCK_TIMEOUT + 1);

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic [WAIT_W-1:0]      wait_q [NUM_REQ];
    logic [WAIT_W-1:0]      wait_d [NUM_REQ];
    logic                   en_q, en_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [ID_W-1:0]        gid_q, gid_d;
    logic                   abort_q, abort_d;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [ID_W-1:0]        arb_idx;
    logic                   arb_any;
    logic [NUM_REQ-1:0]     ready;
    logic                   xfer;
    logic [ID_W-1:0]        win;
    logic [ADDR_WIDTH-1:0]  win_addr;

    function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // Ready must stay low while reset is held, independent of the flops.
    always_comb begin
        ready = '0;
        if (state_q == ARB) begin
            ready = arb_gnt;
        end else begin
            ready[owner_q] = req_valid[owner_q];
        end
        if (rst) begin
            ready = '0;
        end
    end

    assign req_ready = ready;
    assign xfer      = |(req_valid & ready);
    assign win       = (state_q == ARB) ? arb_idx : owner_q;
    assign win_addr  = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        idle_d  = idle_q;
        abort_d = 1'b0;
        unique case (state_q)
            ARB: begin
                if (xfer && arb_any) begin
                    ptr_d = inc_id(win);
                    if (req_lock[win]) begin
                        state_d = LOCKED;
                        owner_d = win;
                        idle_d  = '0;
                    end
                end
            end
            LOCKED: begin
                if (xfer) begin
                    if (req_lock[owner_q]) begin
                        idle_d = '0;
                    end else begin
                        state_d = ARB;
                        ptr_d   = inc_id(owner_q);
                    end
                end else if (idle_q == IDLE_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = ARB;
                    abort_d = 1'b1;
                    ptr_d   = inc_id(owner_q);
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        en_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        gid_d  = gid_q;
        if (xfer) begin
            en_d   = !((ZERO_RO != 0) && (win_addr == '0));
            addr_d = win_addr;
            data_d = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            gid_d  = win;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = '0;
            if (req_valid[i] && !ready[i]) begin
                wait_d[i] = (wait_q[i] == WAIT_W'(MAX_WAIT)) ?
                            wait_q[i] : wait_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            idle_q  <= '0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            gid_q   <= '0;
            abort_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            idle_q  <= idle_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            abort_q <= abort_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            starve[i] = (wait_q[i] == WAIT_W'(MAX_WAIT));
        end
    end

    assign rf_wr_en   = en_q;
    assign rf_wr_addr = addr_q;
    assign rf_wr_data = data_q;
    assign grant_id   = gid_q;
    assign locked     = (state_q == LOCKED);
    assign lock_abort = abort_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench: directed table, hand sequences and random traffic
// against a queue-free rotating-search reference model.
module tb_rf_wr_arbiter;

    localparam int NR = 4, AW = 5, DW = 32, MAXW = 15, TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NR-1:0]    req_valid = '0, req_lock = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_data = '0;

    logic [NR-1:0] ready, ready0, starve, starve0;
    logic en, en0, locked, locked0, abort, abort0;
    logic [AW-1:0] addr, addr0;
    logic [DW-1:0] data, data0;
    logic [1:0] gid, gid0;

    always #5 clk = ~clk;

    rf_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                    .MAX_WAIT(MAXW), .LOCK_TIMEOUT(TO), .ZERO_RO(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready),
        .req_lock(req_lock), .req_addr(req_addr), .req_data(req_data),
        .rf_wr_en(en), .rf_wr_addr(addr), .rf_wr_data(data),
        .grant_id(gid), .locked(locked), .lock_abort(abort), .starve(starve));

    rf_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                    .MAX_WAIT(MAXW), .LOCK_TIMEOUT(TO), .ZERO_RO(0)) dut_z0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready0),
        .req_lock(req_lock), .req_addr(req_addr), .req_data(req_data),
        .rf_wr_en(en0), .rf_wr_addr(addr0), .rf_wr_data(data0),
        .grant_id(gid0), .locked(locked0), .lock_abort(abort0), .starve(starve0));

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    bit m_lock;
    int m_owner, m_ptr, m_idle;
    int m_wait [NR];
    bit e_en1, e_en0, e_abort;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int e_gid;
    logic [NR-1:0] m_rdy;

    function automatic void model_reset();
        m_lock = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
        for (int i = 0; i < NR; i++) m_wait[i] = 0;
        e_en1 = 0; e_en0 = 0; e_abort = 0; e_addr = '0; e_data = '0; e_gid = 0;
    endfunction

    function automatic logic [NR-1:0] model_ready();
        logic [NR-1:0] r = '0;
        bit found = 0;
        if (m_lock) begin
            r[m_owner] = req_valid[m_owner];
        end else begin
            for (int k = 0; k < NR; k++) begin
                int i = (m_ptr + k) % NR;
                if (!found && req_valid[i]) begin
                    r[i] = 1'b1;
                    found = 1;
                end
            end
        end
        return r;
    endfunction

    function automatic void model_step();
        int w = -1;
        e_abort = 0;
        for (int i = 0; i < NR; i++) if (m_rdy[i]) w = i;
        if (w >= 0) begin
            e_addr = req_addr[w*AW +: AW];
            e_data = req_data[w*DW +: DW];
            e_gid  = w;
            e_en0  = 1;
            e_en1  = (e_addr != 0);
        end else begin
            e_en0 = 0;
            e_en1 = 0;
        end
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && !m_rdy[i]) m_wait[i] = (m_wait[i] < MAXW) ? m_wait[i] + 1 : MAXW;
            else m_wait[i] = 0;
        end
        if (!m_lock) begin
            if (w >= 0) begin
                m_ptr = (w + 1) % NR;
                if (req_lock[w]) begin m_lock = 1; m_owner = w; m_idle = 0; end
            end
        end else if (w >= 0) begin
            if (req_lock[w]) m_idle = 0;
            else begin m_lock = 0; m_ptr = (w + 1) % NR; end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_lock = 0; e_abort = 1; m_ptr = (m_owner + 1) % NR; m_idle = 0;
            end
        end
    endfunction

    // One clock: check ready before the edge, registered outputs after it.
    task automatic cycle(output logic [NR-1:0] seen);
        logic [NR-1:0] exp_st;
        #2;
        m_rdy = model_ready();
        seen = ready;
        chk("req_ready", ready, m_rdy);
        chk("req_ready_z0", ready0, m_rdy);
        @(posedge clk);
        model_step();
        #1;
        chk("rf_wr_en", en, e_en1);
        chk("rf_wr_en_z0", en0, e_en0);
        chk("rf_wr_addr", addr, e_addr);
        chk("rf_wr_data", data, e_data);
        chk("grant_id", gid, e_gid);
        chk("locked", locked, m_lock);
        chk("lock_abort", abort, e_abort);
        for (int i = 0; i < NR; i++) exp_st[i] = (m_wait[i] == MAXW);
        chk("starve", starve, exp_st);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_en", en, 0);
        chk("rst_ready", ready, 0);
        chk("rst_locked", locked, 0);
        chk("rst_gid", gid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_abort", abort, 0);
        chk("rst_starve", starve, 0);
        req_valid = '0;
        req_lock = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_pay(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic default_pay();
        for (int i = 0; i < NR; i++) set_pay(i, AW'(i + 1), 32'hA000_0000 + DW'(i));
    endtask

    typedef struct {
        logic [NR-1:0] valid;
        logic [NR-1:0] lock;
        logic [NR-1:0] rdy;
        logic          en;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t tbl [9];
    logic [NR-1:0] seen;

    initial begin
        tbl[0] = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 5'd1};
        tbl[1] = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 5'd2};
        tbl[2] = '{4'b1111, 4'b0000, 4'b0100, 1'b1, 5'd3};
        tbl[3] = '{4'b1111, 4'b0000, 4'b1000, 1'b1, 5'd4};
        tbl[4] = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 5'd1};
        tbl[5] = '{4'b1010, 4'b0000, 4'b0010, 1'b1, 5'd2};
        tbl[6] = '{4'b1001, 4'b0000, 4'b1000, 1'b1, 5'd4};
        tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 5'd4};
        tbl[8] = '{4'b0101, 4'b0000, 4'b0001, 1'b1, 5'd1};

        #2;
        do_reset();
        default_pay();

        // Round-robin table with wrap and idle hold
        for (int t = 0; t < 9; t++) begin
            req_valid = tbl[t].valid;
            req_lock  = tbl[t].lock;
            cycle(seen);
            chk("tbl_ready", seen, tbl[t].rdy);
            chk("tbl_en", en, tbl[t].en);
            chk("tbl_addr", addr, tbl[t].addr);
        end

        // Lock burst by requester 2, then grant moves to 3
        do_reset();
        req_valid = 4'b0100; req_lock = 4'b0100;
        cycle(seen);
        chk("burst_b1_ready", seen, 4'b0100);
        chk("burst_b1_locked", locked, 1);
        req_valid = 4'b1111; req_lock = 4'b0100;
        cycle(seen);
        chk("burst_b2_ready", seen, 4'b0100);
        chk("burst_b2_locked", locked, 1);
        req_valid = 4'b1111; req_lock = 4'b0000;
        cycle(seen);
        chk("burst_b3_ready", seen, 4'b0100);
        chk("burst_b3_locked", locked, 0);
        req_valid = 4'b1011;
        cycle(seen);
        chk("burst_next_ready", seen, 4'b1000);
        chk("burst_next_gid", gid, 3);

        // Lock timeout by requester 1
        do_reset();
        req_valid = 4'b0010; req_lock = 4'b0010;
        cycle(seen);
        chk("to_lock_ready", seen, 4'b0010);
        req_valid = 4'b0000; req_lock = 4'b0000;
        for (int k = 1; k <= TO; k++) begin
            cycle(seen);
            if (k == TO - 1) begin
                chk("to_pre_locked", locked, 1);
                chk("to_pre_abort", abort, 0);
            end
            if (k == TO) begin
                chk("to_locked", locked, 0);
                chk("to_abort", abort, 1);
            end
        end
        req_valid = 4'b0111;
        cycle(seen);
        chk("to_next_ready", seen, 4'b0100);
        chk("to_abort_once", abort, 0);

        // Zero register write
        do_reset();
        set_pay(0, 5'd0, 32'hDEAD_BEEF);
        req_valid = 4'b0001;
        cycle(seen);
        chk("zero_ready", seen, 4'b0001);
        chk("zero_en_ro1", en, 0);
        chk("zero_en_ro0", en0, 1);
        chk("zero_addr_ro0", addr0, 0);
        chk("zero_data_ro0", data0, 32'hDEAD_BEEF);

        // Starvation of requester 3 behind a 20-beat lock from requester 0
        do_reset();
        default_pay();
        for (int b = 1; b <= 20; b++) begin
            req_valid = 4'b1001;
            req_lock  = (b < 20) ? 4'b0001 : 4'b0000;
            cycle(seen);
            if (b == 14) chk("starve_pre", starve[3], 0);
            if (b == 15) chk("starve_set", starve[3], 1);
        end
        chk("starve_hold", starve[3], 1);
        req_valid = 4'b1001; req_lock = 4'b0000;
        cycle(seen);
        chk("starve_grant3", seen, 4'b1000);
        chk("starve_clear", starve[3], 0);

        // Reset mid-burst with a pending registered write
        do_reset();
        req_valid = 4'b0010; req_lock = 4'b0010;
        cycle(seen);
        cycle(seen);
        chk("mid_pending_en", en, 1);
        do_reset();
        req_valid = 4'b1111; req_lock = 4'b0000;
        cycle(seen);
        chk("mid_after_ready", seen, 4'b0001);

        // Random traffic in segments of varying load
        for (int s = 0; s < 14; s++) begin
            int dens = $urandom_range(0, 3);
            for (int c = 0; c < 40; c++) begin
                for (int i = 0; i < NR; i++) begin
                    req_valid[i] = ($urandom_range(0, 3) < dens);
                    req_lock[i]  = ($urandom_range(0, 2) == 0);
                    set_pay(i, AW'($urandom_range(0, 31)), DW'($urandom));
                end
                cycle(seen);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
